// File: rtl/lsu_rmw_master.sv
// Load/store unit for a word-wide RAM with a registered read address.
// Sub-word stores are done as read-modify-write. Optional counters: LSU_PERF_EN.
module lsu_rmw_master #(
   parameter int ADDRWIDTH = 6,
   parameter int DATAWIDTH = 32
) (
   input  logic                   iClk,
   input  logic                   iRst_n,
   input  logic                   iReq,
   input  logic                   iWe,
   input  logic [2:0]             iFunct3,
   input  logic [ADDRWIDTH+1:0]   iAddr,
   input  logic [DATAWIDTH-1:0]   iWData,
   output logic                   oBusy,
   output logic                   oDone,
   output logic                   oErr,
   output logic [DATAWIDTH-1:0]   oRData,
   output logic                   oRamWR,
   output logic [ADDRWIDTH-1:0]   oRamAddress,
   output logic [DATAWIDTH-1:0]   oRamWriteData,
`ifdef LSU_PERF_EN
   output logic [15:0]            oLoadCnt,
   output logic [15:0]            oStoreCnt,
   output logic [15:0]            oErrCnt,
`endif
   input  logic [DATAWIDTH-1:0]   iRamReadData
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DATA,
      WRITE,
      RESP
   } state_t;

   state_t state, state_n;

   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [15:0] wd_q;
   logic        err_q;

   logic        acc;
   logic        f3_bad;
   logic        mis;
   logic        bad;
   logic        is_sw;

   logic [7:0]           lane_b;
   logic [15:0]          lane_h;
   logic [DATAWIDTH-1:0] ext;
   logic [DATAWIDTH-1:0] mrg;

   // Request decode: legality and alignment of the incoming access
   always_comb begin
      acc    = (state == IDLE) && iReq;
      f3_bad = iWe ? (iFunct3[2] || (iFunct3[1:0] == 2'b11))
                   : ((iFunct3 == 3'b011) || (iFunct3[2:1] == 2'b11));
      mis    = ((iFunct3[1:0] == 2'b01) && iAddr[0]) ||
               ((iFunct3[1:0] == 2'b10) && (iAddr[1:0] != 2'b00));
      bad    = f3_bad || mis;
      is_sw  = iWe && (iFunct3[1:0] == 2'b10);
   end

   // State register
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) state <= IDLE;
      else         state <= state_n;
   end

   // Next-state logic; SW skips the read, errors go straight to RESP
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (acc) begin
               if (bad)        state_n = RESP;
               else if (is_sw) state_n = WRITE;
               else            state_n = ADDR;
            end
         end
         ADDR:    state_n = DATA;
         DATA:    state_n = we_q ? WRITE : RESP;
         WRITE:   state_n = RESP;
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Status outputs decoded from state so reset clears them at once
   always_comb begin
      oBusy  = (state != IDLE);
      oDone  = (state == RESP);
      oErr   = (state == RESP) && err_q;
      oRamWR = (state == WRITE);
   end

   // Lane select, load extension and store merge
   always_comb begin
      unique case (off_q)
         2'd0:    lane_b = iRamReadData[7:0];
         2'd1:    lane_b = iRamReadData[15:8];
         2'd2:    lane_b = iRamReadData[23:16];
         default: lane_b = iRamReadData[31:24];
      endcase
      lane_h = off_q[1] ? iRamReadData[31:16] : iRamReadData[15:0];
      unique case (f3_q)
         3'b000:  ext = {{24{lane_b[7]}}, lane_b};
         3'b001:  ext = {{16{lane_h[15]}}, lane_h};
         3'b100:  ext = {24'h0, lane_b};
         3'b101:  ext = {16'h0, lane_h};
         default: ext = iRamReadData;
      endcase
      mrg = iRamReadData;
      if (f3_q[1:0] == 2'b00) begin
         unique case (off_q)
            2'd0:    mrg[7:0]   = wd_q[7:0];
            2'd1:    mrg[15:8]  = wd_q[7:0];
            2'd2:    mrg[23:16] = wd_q[7:0];
            default: mrg[31:24] = wd_q[7:0];
         endcase
      end else begin
         if (off_q[1]) mrg[31:16] = wd_q;
         else          mrg[15:0]  = wd_q;
      end
   end

   // Request capture on accept, read data capture in DATA
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         we_q          <= 1'b0;
         f3_q          <= 3'b000;
         off_q         <= 2'b00;
         wd_q          <= 16'h0;
         err_q         <= 1'b0;
         oRamAddress   <= '0;
         oRamWriteData <= '0;
         oRData        <= '0;
      end else begin
         if (acc) begin
            we_q        <= iWe;
            f3_q        <= iFunct3;
            off_q       <= iAddr[1:0];
            wd_q        <= iWData[15:0];
            err_q       <= bad;
            oRamAddress <= iAddr[ADDRWIDTH+1:2];
            if (is_sw && !bad) oRamWriteData <= iWData;
         end
         if (state == DATA) begin
            if (we_q) oRamWriteData <= mrg;
            else      oRData        <= ext;
         end
      end
   end

`ifdef LSU_PERF_EN
   // Saturating transaction counters, bumped in RESP
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         oLoadCnt  <= 16'h0;
         oStoreCnt <= 16'h0;
         oErrCnt   <= 16'h0;
      end else if (state == RESP) begin
         if (err_q) begin
            if (oErrCnt != 16'hFFFF) oErrCnt <= oErrCnt + 16'd1;
         end else if (we_q) begin
            if (oStoreCnt != 16'hFFFF) oStoreCnt <= oStoreCnt + 16'd1;
         end else begin
            if (oLoadCnt != 16'hFFFF) oLoadCnt <= oLoadCnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_lsu_rmw_master.sv
// Directed self-checking bench for lsu_rmw_master with a registered-read RAM.
module tb_lsu_rmw_master;

   logic        iClk = 1'b0;
   logic        iRst_n = 1'b0;
   logic        iReq = 1'b0;
   logic        iWe = 1'b0;
   logic [2:0]  iFunct3 = 3'b000;
   logic [7:0]  iAddr = 8'h00;
   logic [31:0] iWData = 32'h0;
   logic        oBusy, oDone, oErr, oRamWR;
   logic [31:0] oRData, oRamWriteData, iRamReadData;
   logic [5:0]  oRamAddress;
`ifdef LSU_PERF_EN
   logic [15:0] oLoadCnt, oStoreCnt, oErrCnt;
`endif

   logic [31:0] mem [0:63];
   logic [5:0]  ra_q;
   logic        pl_we = 1'b0;
   logic [5:0]  pl_a = 6'd0;
   logic [31:0] pl_d = 32'h0;

   int checks = 0;
   int failures = 0;
   int lat, wrs;
   logic err;

   always #5 iClk = ~iClk;

   lsu_rmw_master #(.ADDRWIDTH(6), .DATAWIDTH(32)) dut (
      .iClk(iClk),
      .iRst_n(iRst_n),
      .iReq(iReq),
      .iWe(iWe),
      .iFunct3(iFunct3),
      .iAddr(iAddr),
      .iWData(iWData),
      .oBusy(oBusy),
      .oDone(oDone),
      .oErr(oErr),
      .oRData(oRData),
      .oRamWR(oRamWR),
      .oRamAddress(oRamAddress),
      .oRamWriteData(oRamWriteData),
`ifdef LSU_PERF_EN
      .oLoadCnt(oLoadCnt),
      .oStoreCnt(oStoreCnt),
      .oErrCnt(oErrCnt),
`endif
      .iRamReadData(iRamReadData)
   );

   always @(posedge iClk) begin
      ra_q <= oRamAddress;
      if (pl_we)       mem[pl_a] <= pl_d;
      else if (oRamWR) mem[oRamAddress] <= oRamWriteData;
   end
   assign iRamReadData = mem[ra_q];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [5:0] a, input logic [31:0] d);
      @(negedge iClk);
      pl_we = 1'b1;
      pl_a  = a;
      pl_d  = d;
      @(negedge iClk);
      pl_we = 1'b0;
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3,
                         input logic [7:0] a, input logic [31:0] wd,
                         output int l, output int w, output logic e);
      @(negedge iClk);
      iReq = 1'b1;
      iWe = we;
      iFunct3 = f3;
      iAddr = a;
      iWData = wd;
      @(negedge iClk);
      iReq = 1'b0;
      l = 0;
      w = 0;
      e = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         if (oRamWR) w++;
         if (oDone) begin
            l = i;
            e = oErr;
            break;
         end
         @(negedge iClk);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) preload(i[5:0], 32'h0);
      preload(6'd3, 32'h8012_34F6);
      preload(6'd5, 32'hAABB_CCDD);
      @(negedge iClk);
      chk("rst_busy", {31'h0, oBusy}, 32'h0);
      chk("rst_done", {31'h0, oDone}, 32'h0);
      chk("rst_err", {31'h0, oErr}, 32'h0);
      chk("rst_wr", {31'h0, oRamWR}, 32'h0);
      chk("rst_rdata", oRData, 32'h0);
      chk("rst_addr", {26'h0, oRamAddress}, 32'h0);
      chk("rst_wdata", oRamWriteData, 32'h0);
      iRst_n = 1'b1;

      do_req(1'b0, 3'b000, 8'h0F, 32'h0, lat, wrs, err);
      chk("lb_lat", lat, 3);
      chk("lb_err", {31'h0, err}, 32'h0);
      chk("lb_wr", wrs, 0);
      chk("lb_data", oRData, 32'hFFFF_FF80);
      @(negedge iClk);
      chk("lb_idle", {31'h0, oBusy}, 32'h0);

      do_req(1'b0, 3'b101, 8'h0C, 32'h0, lat, wrs, err);
      chk("lhu_lat", lat, 3);
      chk("lhu_data", oRData, 32'h0000_34F6);
      do_req(1'b0, 3'b001, 8'h0E, 32'h0, lat, wrs, err);
      chk("lh_data", oRData, 32'hFFFF_8012);

      do_req(1'b1, 3'b000, 8'h15, 32'h0000_0011, lat, wrs, err);
      chk("sb_lat", lat, 4);
      chk("sb_wr", wrs, 1);
      @(negedge iClk);
      chk("sb_mem", mem[5], 32'hAABB_11DD);
      do_req(1'b1, 3'b001, 8'h16, 32'h0000_7777, lat, wrs, err);
      chk("sh_wr", wrs, 1);
      @(negedge iClk);
      chk("sh_mem", mem[5], 32'h7777_11DD);

      do_req(1'b1, 3'b010, 8'h08, 32'hDEAD_BEEF, lat, wrs, err);
      chk("sw_lat", lat, 2);
      chk("sw_wr", wrs, 1);
      chk("sw_err", {31'h0, err}, 32'h0);
      @(negedge iClk);
      chk("sw_mem", mem[2], 32'hDEAD_BEEF);

      do_req(1'b0, 3'b010, 8'h06, 32'h0, lat, wrs, err);
      chk("lw_mis_lat", lat, 1);
      chk("lw_mis_err", {31'h0, err}, 32'h1);
      chk("lw_mis_rdata", oRData, 32'hFFFF_8012);
      do_req(1'b1, 3'b001, 8'h03, 32'h0000_ABCD, lat, wrs, err);
      chk("sh_mis_lat", lat, 1);
      chk("sh_mis_err", {31'h0, err}, 32'h1);
      chk("sh_mis_wr", wrs, 0);
      @(negedge iClk);
      chk("sh_mis_mem", mem[0], 32'h0);
      do_req(1'b0, 3'b011, 8'h0C, 32'h0, lat, wrs, err);
      chk("ill_f3_err", {31'h0, err}, 32'h1);
      chk("ill_f3_rdata", oRData, 32'hFFFF_8012);

      @(negedge iClk);
      iReq = 1'b1;
      iWe = 1'b1;
      iFunct3 = 3'b000;
      iAddr = 8'h14;
      iWData = 32'h0000_0055;
      @(negedge iClk);
      iReq = 1'b0;
      @(negedge iClk);
      chk("abort_pre_busy", {31'h0, oBusy}, 32'h1);
      iRst_n = 1'b0;
      #1;
      chk("abort_wr", {31'h0, oRamWR}, 32'h0);
      chk("abort_busy", {31'h0, oBusy}, 32'h0);
      chk("abort_rdata", oRData, 32'h0);
      wrs = 0;
      repeat (2) begin
         @(negedge iClk);
         if (oRamWR) wrs++;
      end
      iRst_n = 1'b1;
      repeat (5) begin
         @(negedge iClk);
         if (oRamWR) wrs++;
      end
      chk("abort_no_wr", wrs, 0);
      chk("abort_mem", mem[5], 32'h7777_11DD);

      @(negedge iClk);
      iReq = 1'b1;
      iWe = 1'b0;
      iFunct3 = 3'b010;
      iAddr = 8'h0C;
      @(negedge iClk);
      iWe = 1'b1;
      iAddr = 8'h00;
      iWData = 32'h0000_1234;
      @(negedge iClk);
      iReq = 1'b0;
      @(negedge iClk);
      chk("busy_done", {31'h0, oDone}, 32'h1);
      chk("busy_rdata", oRData, 32'h8012_34F6);
      @(negedge iClk);
      chk("busy_ign_idle", {31'h0, oBusy}, 32'h0);
      repeat (3) @(negedge iClk);
      chk("busy_ign_mem", mem[0], 32'h0);

      do_req(1'b0, 3'b100, 8'h0D, 32'h0, lat, wrs, err);
      chk("lbu_data", oRData, 32'h0000_0034);
      do_req(1'b1, 3'b010, 8'h10, 32'h0102_0304, lat, wrs, err);
      @(negedge iClk);
      chk("sw2_mem", mem[4], 32'h0102_0304);
      do_req(1'b0, 3'b001, 8'h01, 32'h0, lat, wrs, err);
      chk("lh_mis_err", {31'h0, err}, 32'h1);
      @(negedge iClk);
`ifdef LSU_PERF_EN
      chk("cnt_load", {16'h0, oLoadCnt}, 32'd2);
      chk("cnt_store", {16'h0, oStoreCnt}, 32'd1);
      chk("cnt_err", {16'h0, oErrCnt}, 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
